// File: rtl/mat_row_bank_if.sv
// Bus bundle for mat_row_bank: load stream, engine read/write port, drain stream and status.
// The bank binds to the slave modport; the producer/engines/consumer side uses master.
interface mat_row_bank_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 64
);
    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned RW = SIZE * 2 * WIDTH;

    logic          flush_i;
    logic          load_start_i;
    logic [RW-1:0] load_row_i;
    logic          load_valid_i;
    logic          load_ready_o;
    logic [AW-1:0] rd_addr_i;
    logic          rd_addr_valid_i;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic [RW-1:0] wr_row_i;
    logic [AW-1:0] wr_addr_i;
    logic          wr_valid_i;
    logic          drain_start_i;
    logic          drain_transpose_i;
    logic [RW-1:0] out_row_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          full_o;
    logic          busy_o;

    modport slave (
        input  flush_i, load_start_i, load_row_i, load_valid_i,
        input  rd_addr_i, rd_addr_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
        input  drain_start_i, drain_transpose_i, out_ready_i,
        output load_ready_o, rd_row_o, rd_addr_o, rd_valid_o,
        output out_row_o, out_valid_o, out_last_o, full_o, busy_o
    );

    modport master (
        output flush_i, load_start_i, load_row_i, load_valid_i,
        output rd_addr_i, rd_addr_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
        output drain_start_i, drain_transpose_i, out_ready_i,
        input  load_ready_o, rd_row_o, rd_addr_o, rd_valid_o,
        input  out_row_o, out_valid_o, out_last_o, full_o, busy_o
    );
endinterface

// File: rtl/mat_row_bank.sv
// Row-organised SIZE x SIZE complex matrix store feeding the lu / triang_matrix_inv engines.
// Loads from a row stream, serves 1-cycle row reads and write-backs, drains rows or columns.
module mat_row_bank #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    mat_row_bank_if.slave bus
);
    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned EW = 2 * WIDTH;
    localparam int unsigned RW = SIZE * EW;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          transpose_q, transpose_d;
    logic          full_q, full_d;
    logic          load_ready_q, load_ready_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          rd_valid_q, rd_valid_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic [RW-1:0] mem_q [SIZE];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [RW-1:0] mem_wdata;

    logic [AW-1:0] beat_idx;
    logic [RW-1:0] out_row_c;

    // Next-state, counters, storage write port and registered outputs.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        transpose_d = transpose_q;
        full_d      = full_q;
        rd_valid_d  = 1'b0;
        rd_row_d    = rd_row_q;
        rd_addr_d   = rd_addr_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        if (bus.flush_i) begin
            state_d    = S_IDLE;
            load_cnt_d = '0;
            beat_cnt_d = '0;
            full_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_start_i) begin
                        state_d    = S_LOAD;
                        load_cnt_d = '0;
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid_i) begin
                        mem_we     = 1'b1;
                        mem_waddr  = load_cnt_q[AW-1:0];
                        mem_wdata  = bus.load_row_i;
                        load_cnt_d = load_cnt_q + CW'(1);
                        if (load_cnt_q == LAST) begin
                            state_d    = S_READY;
                            load_cnt_d = '0;
                            full_d     = 1'b1;
                        end
                    end
                end
                S_READY: begin
                    // Read samples the pre-write array, so a same-address write returns the old row.
                    if (bus.rd_addr_valid_i) begin
                        rd_valid_d = 1'b1;
                        rd_row_d   = mem_q[bus.rd_addr_i];
                        rd_addr_d  = bus.rd_addr_i;
                    end
                    if (bus.wr_valid_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.wr_addr_i;
                        mem_wdata = bus.wr_row_i;
                    end
                    if (bus.drain_start_i) begin
                        state_d     = S_DRAIN;
                        transpose_d = bus.drain_transpose_i;
                        beat_cnt_d  = '0;
                    end else if (bus.load_start_i) begin
                        state_d    = S_LOAD;
                        load_cnt_d = '0;
                        full_d     = 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready_i) begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                        if (beat_cnt_q == LAST) begin
                            state_d    = S_READY;
                            beat_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        load_ready_d = (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD) || (state_d == S_DRAIN);
        out_valid_d  = (state_d == S_DRAIN);
        out_last_d   = (state_d == S_DRAIN) && (beat_cnt_d == LAST);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            transpose_q  <= 1'b0;
            full_q       <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_row_q     <= '0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            transpose_q  <= transpose_d;
            full_q       <= full_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            rd_valid_q   <= rd_valid_d;
            rd_row_q     <= rd_row_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign beat_idx = beat_cnt_q[AW-1:0];

    // Drain beat read straight from the array; no writes occur in DRAIN so it holds under stall.
    always_comb begin
        out_row_c = '0;
        if (state_q == S_DRAIN) begin
            if (transpose_q) begin
                for (int j = 0; j < SIZE; j++) begin
                    out_row_c[j*EW +: EW] = mem_q[AW'(j)][int'(beat_idx)*EW +: EW];
                end
            end else begin
                out_row_c = mem_q[beat_idx];
            end
        end
    end

    assign bus.load_ready_o = load_ready_q;
    assign bus.rd_row_o     = rd_row_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.out_row_o    = out_row_c;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_last_o   = out_last_q;
    assign bus.full_o       = full_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_mat_row_bank.sv
// Directed + randomized bench for mat_row_bank against an array model of the matrix.
module tb_mat_row_bank;
    localparam int unsigned SIZE  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned AW    = $clog2(SIZE);
    localparam int unsigned EW    = 2 * WIDTH;
    localparam int unsigned RW    = SIZE * EW;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [RW-1:0] mdl [SIZE];

    mat_row_bank_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    mat_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input int i);
        logic [RW-1:0] r;
        real v;
        r = '0;
        for (int j = 0; j < SIZE; j++) begin
            v = real'(4 * i + j);
            r[j*EW +: WIDTH]         = $realtobits(v);
            r[j*EW + WIDTH +: WIDTH] = $realtobits(-v);
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected drain beat: row b, or column b gathered from every row.
    function automatic logic [RW-1:0] exp_beat(input int b, input bit t);
        logic [RW-1:0] r;
        logic [RW-1:0] src;
        if (!t) return mdl[b];
        r = '0;
        for (int j = 0; j < SIZE; j++) begin
            src = mdl[j];
            r[j*EW +: EW] = src[b*EW +: EW];
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus.flush_i           = 1'b0;
        bus.load_start_i      = 1'b0;
        bus.load_row_i        = '0;
        bus.load_valid_i      = 1'b0;
        bus.rd_addr_i         = '0;
        bus.rd_addr_valid_i   = 1'b0;
        bus.wr_row_i          = '0;
        bus.wr_addr_i         = '0;
        bus.wr_valid_i        = 1'b0;
        bus.drain_start_i     = 1'b0;
        bus.drain_transpose_i = 1'b0;
        bus.out_ready_i       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_load_ready"}, bus.load_ready_o, 1'b0);
        check_bit({tag, "_rd_valid"}, bus.rd_valid_o, 1'b0);
        check({tag, "_rd_row"}, bus.rd_row_o, '0);
        check({tag, "_rd_addr"}, RW'(bus.rd_addr_o), '0);
        check_bit({tag, "_out_valid"}, bus.out_valid_o, 1'b0);
        check_bit({tag, "_out_last"}, bus.out_last_o, 1'b0);
        check({tag, "_out_row"}, bus.out_row_o, '0);
        check_bit({tag, "_full"}, bus.full_o, 1'b0);
        check_bit({tag, "_busy"}, bus.busy_o, 1'b0);
    endtask

    // Full load of the model rows with gap cycles before odd rows.
    task automatic load_matrix(input int gap);
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        check_bit("load_ready_on", bus.load_ready_o, 1'b1);
        check_bit("load_busy", bus.busy_o, 1'b1);
        for (int i = 0; i < SIZE; i++) begin
            if (i % 2 == 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.load_valid_i = 1'b0;
                    tick();
                    check_bit("load_gap_ready", bus.load_ready_o, 1'b1);
                end
            end
            bus.load_valid_i = 1'b1;
            bus.load_row_i   = mdl[i];
            tick();
            check_bit("load_full", bus.full_o, (i == SIZE - 1));
        end
        bus.load_valid_i = 1'b0;
        check_bit("load_ready_off", bus.load_ready_o, 1'b0);
        check_bit("load_busy_off", bus.busy_o, 1'b0);
    endtask

    task automatic read_row(input int a);
        bus.rd_addr_valid_i = 1'b1;
        bus.rd_addr_i       = AW'(a);
        tick();
        bus.rd_addr_valid_i = 1'b0;
        check_bit("rd_valid", bus.rd_valid_o, 1'b1);
        check("rd_addr", RW'(bus.rd_addr_o), RW'(a));
        check("rd_row", bus.rd_row_o, mdl[a]);
    endtask

    // Drain with ready pattern (mode 0) or random ready (mode 1); rd/wr noise must be ignored.
    task automatic do_drain(input bit t, input bit with_load, input int mode, input bit chk_tp);
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int b;
        int cyc;
        bit rdy;
        bus.drain_start_i     = 1'b1;
        bus.drain_transpose_i = t;
        bus.load_start_i      = with_load;
        tick();
        bus.drain_start_i = 1'b0;
        bus.load_start_i  = 1'b0;
        check_bit("drain_busy", bus.busy_o, 1'b1);
        check_bit("drain_not_load", bus.load_ready_o, 1'b0);
        b   = 0;
        cyc = 0;
        while (b < SIZE && cyc < 64) begin
            rdy = (mode == 0) ? ((cyc < 6) ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
            bus.out_ready_i     = rdy;
            bus.rd_addr_valid_i = 1'($urandom_range(0, 1));
            bus.rd_addr_i       = AW'($urandom_range(0, SIZE - 1));
            bus.wr_valid_i      = 1'($urandom_range(0, 1));
            bus.wr_addr_i       = AW'($urandom_range(0, SIZE - 1));
            bus.wr_row_i        = rand_row();
            check_bit("drain_valid", bus.out_valid_o, 1'b1);
            check("drain_row", bus.out_row_o, exp_beat(b, t));
            check_bit("drain_last", bus.out_last_o, (b == SIZE - 1));
            check_bit("drain_rd_ignored", bus.rd_valid_o, 1'b0);
            if (chk_tp && b == 2) begin
                for (int j = 0; j < SIZE; j++) begin
                    check("tp_beat2_real", RW'(bus.out_row_o[j*EW +: WIDTH]),
                          RW'($realtobits(real'(2 + 4 * j))));
                end
            end
            tick();
            cyc++;
            if (rdy) b++;
        end
        check_bit("drain_done", (b == SIZE), 1'b1);
        bus.out_ready_i     = 1'b0;
        bus.rd_addr_valid_i = 1'b0;
        bus.wr_valid_i      = 1'b0;
        check_bit("drain_exit_valid", bus.out_valid_o, 1'b0);
        check_bit("drain_exit_busy", bus.busy_o, 1'b0);
        check_bit("drain_exit_full", bus.full_o, 1'b1);
        check_bit("drain_exit_rd", bus.rd_valid_o, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] old_row;
        logic [RW-1:0] sevens;
        logic [RW-1:0] wd;
        int ra;
        int wa;
        bit rv;
        bit wv;
        tests = 0;
        fails = 0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Requests other than load_start are ignored in IDLE.
        bus.drain_start_i   = 1'b1;
        bus.rd_addr_valid_i = 1'b1;
        bus.load_valid_i    = 1'b1;
        tick();
        idle_inputs();
        check_bit("idle_busy", bus.busy_o, 1'b0);
        check_bit("idle_out_valid", bus.out_valid_o, 1'b0);
        check_bit("idle_rd_valid", bus.rd_valid_o, 1'b0);

        // Plan matrix, once without gaps and once with 2-cycle gaps.
        for (int i = 0; i < SIZE; i++) mdl[i] = mk_row(i);
        load_matrix(0);
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        check_bit("reload_full_clr", bus.full_o, 1'b0);
        bus.load_valid_i = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            bus.load_row_i = mdl[i];
            tick();
        end
        bus.load_valid_i = 1'b0;
        check_bit("reload_full", bus.full_o, 1'b1);
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_row_i   = mdl[i];
            tick();
            bus.load_valid_i = 1'b0;
            if (i % 2 == 0) begin
                tick();
                tick();
            end
        end
        check_bit("gap_load_full", bus.full_o, 1'b1);

        // Back-to-back reads 3,0,2.
        read_row(3);
        check("rd3_e1_real", RW'(bus.rd_row_o[EW +: WIDTH]), RW'($realtobits(13.0)));
        read_row(0);
        check("rd0_e1_real", RW'(bus.rd_row_o[EW +: WIDTH]), RW'($realtobits(1.0)));
        read_row(2);
        check("rd2_e1_real", RW'(bus.rd_row_o[EW +: WIDTH]), RW'($realtobits(9.0)));
        tick();
        check_bit("rd_idle_valid", bus.rd_valid_o, 1'b0);
        check("rd_idle_hold", bus.rd_row_o, mdl[2]);

        // Same-cycle read/write of row 1 returns the old row.
        for (int j = 0; j < 2 * SIZE; j++) sevens[j*WIDTH +: WIDTH] = $realtobits(7.0);
        old_row             = mdl[1];
        bus.rd_addr_valid_i = 1'b1;
        bus.rd_addr_i       = AW'(1);
        bus.wr_valid_i      = 1'b1;
        bus.wr_addr_i       = AW'(1);
        bus.wr_row_i        = sevens;
        tick();
        bus.rd_addr_valid_i = 1'b0;
        bus.wr_valid_i      = 1'b0;
        check("rbw_old", bus.rd_row_o, old_row);
        check("rbw_old_e3", RW'(bus.rd_row_o[3*EW +: WIDTH]), RW'($realtobits(7.0 - 0.0 + 0.0)));
        mdl[1] = sevens;
        read_row(1);

        // Restore row 1 so the transposed drain sees the plan matrix.
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = AW'(1);
        bus.wr_row_i   = mk_row(1);
        tick();
        bus.wr_valid_i = 1'b0;
        mdl[1] = mk_row(1);
        read_row(1);

        do_drain(1'b0, 1'b0, 0, 1'b0);
        do_drain(1'b1, 1'b1, 1, 1'b1);

        // Random reads/writes plus stray load_valid, scored against the array model.
        for (int n = 0; n < 60; n++) begin
            rv = 1'($urandom_range(0, 1));
            wv = 1'($urandom_range(0, 1));
            ra = int'($urandom_range(0, SIZE - 1));
            wa = int'($urandom_range(0, SIZE - 1));
            wd = rand_row();
            bus.rd_addr_valid_i = rv;
            bus.rd_addr_i       = AW'(ra);
            bus.wr_valid_i      = wv;
            bus.wr_addr_i       = AW'(wa);
            bus.wr_row_i        = wd;
            bus.load_valid_i    = 1'($urandom_range(0, 1));
            bus.load_row_i      = rand_row();
            old_row             = mdl[ra];
            tick();
            check_bit("rnd_rd_valid", bus.rd_valid_o, rv);
            if (rv) begin
                check("rnd_rd_row", bus.rd_row_o, old_row);
                check("rnd_rd_addr", RW'(bus.rd_addr_o), RW'(ra));
            end
            if (wv) mdl[wa] = wd;
        end
        idle_inputs();
        do_drain(1'b1, 1'b0, 1, 1'b0);
        do_drain(1'b0, 1'b0, 1, 1'b0);

        // Reset after two drain beats abandons the transfer.
        bus.drain_start_i = 1'b1;
        tick();
        bus.drain_start_i = 1'b0;
        bus.out_ready_i   = 1'b1;
        tick();
        tick();
        check_bit("pre_rst_valid", bus.out_valid_o, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("mid_drain_rst");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("post_rst_no_beat", bus.out_valid_o, 1'b0);
        end
        bus.out_ready_i = 1'b0;

        // Flush during LOAD after one row, then a clean reload starting at row 0.
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        bus.load_valid_i = 1'b1;
        bus.load_row_i   = rand_row();
        tick();
        bus.load_valid_i = 1'b0;
        bus.flush_i      = 1'b1;
        bus.load_start_i = 1'b1;
        tick();
        bus.flush_i      = 1'b0;
        bus.load_start_i = 1'b0;
        check_bit("flush_busy", bus.busy_o, 1'b0);
        check_bit("flush_ready", bus.load_ready_o, 1'b0);
        check_bit("flush_full", bus.full_o, 1'b0);
        check_bit("flush_out_valid", bus.out_valid_o, 1'b0);
        for (int i = 0; i < SIZE; i++) mdl[i] = rand_row();
        load_matrix(2);
        for (int i = 0; i < SIZE; i++) read_row(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mat_row_bank.md
Name: mat_row_bank

Overview:
- Row-organised storage stage that sits directly upstream of the lu and triang_matrix_inv engines.
- Loads a SIZE x SIZE complex double-precision matrix from a row stream.
- Serves the engines' row-read requests with 1-cycle latency and accepts their row write-backs.
- Drains the final matrix row-wise or column-wise (transposed) to the next consumer.

Parameters:
- SIZE, 4, matrix dimension (rows = cols); power of two, >= 2.
- WIDTH, 64, bits per real/imag part (IEEE double); element = {imag, real}, 2*WIDTH bits.
- Derived: AW = $clog2(SIZE), RW = SIZE*2*WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  abort to IDLE
- load_start_i  in  1  begin loading a new matrix
- load_row_i  in  RW  incoming row; element j at bits [j*2*WIDTH +: 2*WIDTH]
- load_valid_i  in  1  load_row_i valid
- load_ready_o  out  1  bank accepts a load row
- rd_addr_i  in  AW  engine row-read address
- rd_addr_valid_i  in  1  read request
- rd_row_o  out  RW  read data
- rd_addr_o  out  AW  address echoed with the data
- rd_valid_o  out  1  rd_row_o/rd_addr_o valid
- wr_row_i  in  RW  engine write-back row
- wr_addr_i  in  AW  write-back address
- wr_valid_i  in  1  write-back strobe
- drain_start_i  in  1  begin draining
- drain_transpose_i  in  1  sampled with drain_start_i; 1 = output columns
- out_row_o  out  RW  drained row/column
- out_valid_o  out  1  drain beat valid
- out_ready_i  in  1  consumer accepts the beat
- out_last_o  out  1  final beat
- full_o  out  1  matrix fully loaded and resident
- busy_o  out  1  high in LOAD or DRAIN

Behaviour:
Reset and flush
- Synchronous active-low reset on rst_ni.
- Reset: state = IDLE; load_cnt, beat_cnt and transpose_q = 0; all outputs 0.
- Storage contents are not cleared by reset.
- flush_i (sampled each cycle) forces IDLE, clears counters and clears full_o. It does not clear storage and has priority over every other input.
- Reset or flush mid-LOAD or mid-DRAIN abandons the transfer; no further beats are produced.

State machine: IDLE, LOAD, READY, DRAIN
IDLE
- load_start_i -> LOAD, load_cnt = 0.
- All other requests are ignored.
LOAD
- load_ready_o = 1.
- Each cycle with load_valid_i: mem[load_cnt] <= load_row_i, load_cnt++.
- On acceptance of row SIZE-1: -> READY, full_o = 1 from the next cycle.
- rd and wr requests are ignored.
READY
- Read: rd_addr_valid_i at cycle N gives rd_row_o = mem[rd_addr_i], rd_addr_o = rd_addr_i and rd_valid_o = 1 at cycle N+1 (registered).
- Otherwise rd_valid_o = 0 the next cycle; rd_row_o/rd_addr_o hold their last value.
- Write: wr_valid_i -> mem[wr_addr_i] <= wr_row_i at the clock edge.
- Read and write to the same address in the same cycle returns the OLD row (read-before-write).
- Back-to-back reads every cycle are supported, at one read per cycle.
- drain_start_i -> DRAIN; latch transpose_q = drain_transpose_i; beat_cnt = 0.
- load_start_i -> LOAD, full_o = 0.
- If drain_start_i and load_start_i assert together, drain wins.
- A rd/wr on the transition cycle is still serviced.
DRAIN
- out_valid_o = 1 (combinational from state); out_last_o = (beat_cnt == SIZE-1).
- transpose_q = 0: out_row_o = mem[beat_cnt].
- transpose_q = 1: element j of out_row_o = element beat_cnt of mem[j].
- out_row_o must stay stable while out_valid_o && !out_ready_i.
- On out_valid_o && out_ready_i: beat_cnt++. After the last beat -> READY with full_o still 1.
- rd and wr requests are ignored; rd_valid_o = 0.

Other rules
- busy_o = (state == LOAD || state == DRAIN).
- Counters are AW+1 bits or compared at SIZE-1; no wrap past SIZE-1.
- load_valid_i outside LOAD is ignored; it does not fault.

Test Plan:
1. Load with SIZE=4, elements real = 4i+j, imag = -(4i+j) ($realtobits); rows fed with load_valid_i gaps of 0 and 2 cycles.
   -> full_o rises 1 cycle after the 4th accepted row; load_ready_o low thereafter.
2. Read addresses 3,0,2 issued on consecutive cycles.
   -> rd_valid_o high for 3 cycles starting 1 cycle later; rd_addr_o = 3,0,2; rd_row_o element 1 real = 13.0, 1.0, 9.0.
3. Same cycle rd_addr=1 and wr_addr=1 with a row of all 7.0, then read row 1 again.
   -> first read returns the old row (real 4,5,6,7); second returns all 7.0.
4. Row drain with out_ready_i toggling 1,0,0,1,1,1.
   -> 4 beats in order rows 0..3; data held during stalls; out_last_o only on the 4th beat; state returns to READY.
5. Transposed drain.
   -> beat 2 real parts = 2.0, 6.0, 10.0, 14.0; out_last_o on beat 3.
6. rst_ni low for 1 cycle after 2 drain beats, then flush_i during LOAD after 1 row.
   -> all outputs 0, IDLE; no further out_valid_o; full_o = 0; next load_start_i reloads from row 0.
